// File: rtl/serial_subtractor_ctrl_if.sv
// Request/response bundle for serial_subtractor_ctrl.
// With SERSUB_OVF_EN defined, the bundle also carries the signed-overflow flag ovf.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERSUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, borrow, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A-B controller: one bit per cycle, LSB first, through two half subtractors.
// Optional SERSUB_OVF_EN adds a registered signed-overflow flag.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_subtractor_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bflop_q, bflop_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic d1, b1, d, b2, bout;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor slice: two half subtractors plus an OR on the borrows.
    always_comb begin
        d1       = a_sh_q[0] ^ b_sh_q[0];
        b1       = ~a_sh_q[0] & b_sh_q[0];
        d        = d1 ^ bflop_q;
        b2       = ~d1 & bflop_q;
        bout     = b1 | b2;
        res_next = {d, res_sh_q[WIDTH-1:1]};
    end

`ifdef SERSUB_OVF_EN
    // Operand MSBs are shifted out during RUN, so they are kept aside at accept.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        diff_d   = diff_q;
        bflop_d  = bflop_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
`ifdef SERSUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    bflop_d = 1'b0;
                    cnt_d   = '0;
`ifdef SERSUB_OVF_EN
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_next;
                bflop_d  = bout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    diff_d   = res_next;
                    borrow_d = bout;
`ifdef SERSUB_OVF_EN
                    ovf_d    = (a_msb_q != b_msb_q) && (d != a_msb_q);
`endif
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            diff_q   <= '0;
            bflop_q  <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            diff_q   <= diff_d;
            bflop_q  <= bflop_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef SERSUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl: the driver queues hand-computed results and
// their expected done cycle, and a negedge monitor pops and compares on each done pulse.
module tb_serial_subtractor_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    logic [W-1:0] last_diff;
    exp_t sb[$];

    serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done seen with empty queue (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("diff", 32'(bus.diff), 32'(e.diff));
                chk("borrow", 32'(bus.borrow), 32'(e.borrow));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_in_done", 32'(bus.busy), 32'd1);
`ifdef SERSUB_OVF_EN
                chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within 20 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] ed, input logic eb, input logic eo, input int dcyc);
        exp_t e;
        e.diff = ed; e.borrow = eb; e.ovf = eo; e.cyc = dcyc;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        bus.start = 1'b1; bus.a = ta; bus.b = tb_v;
        push_exp(ed, eb, eo, cyc + 1 + W);
        @(negedge clk);
        bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom);
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        chk("diff_hold_run", 32'(bus.diff), 32'(last_diff));
        wait_done();
        last_diff = ed;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0; last_diff = '0;
        rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

        // Start pulsed in RUN cycle 3 must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h09; bus.b = 8'h04;
        push_exp(8'h05, 1'b0, 1'b0, cyc + 1 + W);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        last_diff = 8'h05;
        repeat (12) @(negedge clk);

        // Start held high: one accept every W+2 cycles.
        bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h11;
        for (int i = 0; i < 3; i++) push_exp(8'h22, 1'b0, 1'b0, cyc + 1 + W + i * (W + 2));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wait_done();
        end
        bus.start = 1'b0;
        last_diff = 8'h22;
        repeat (W + 4) @(negedge clk);

        // Reset in RUN cycle 4 with a new request pending: outputs clear, op is dropped.
        bus.start = 1'b1; bus.a = 8'h44; bus.b = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h01;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_done", 32'(bus.done), 32'd0);
        chk("async_rst_diff", 32'(bus.diff), 32'd0);
        chk("async_rst_borrow", 32'(bus.borrow), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_diff = '0;
        repeat (12) @(negedge clk);

        run_op(8'h80, 8'h7F, 8'h01, 1'b0, 1'b1);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

        repeat (15) @(negedge clk);
        chk("queue_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
- Controller that runs a WIDTH-bit subtraction A-B over multiple cycles, LSB first.
- Each cycle it sequences one bit through a 1-bit full-subtractor slice, built from two half subtractors plus an OR, and holds the borrow in a flip-flop between cycles.
- Sits between a requester (start/done handshake) and the single-bit subtractor datapath. It trades area for latency and reuses the existing half-subtractor cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 2.
- Derived internally, not a parameter: counter width CNT_W = $clog2(WIDTH).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while an operation is in flight (RUN or DONE).
- done  output  1  single-cycle pulse; diff/borrow valid and updated this cycle.
- diff  output  WIDTH  (a-b) mod 2^WIDTH; holds until the next done.
- borrow  output  1  final borrow out; 1 iff a<b unsigned; holds until the next done.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, ports named clk and rst_n.
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, busy=0, done=0, diff=0, borrow=0.
  - Operand shift regs, result shift reg, borrow flop and counter all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load a_sh<=a, b_sh<=b, bflop<=0, cnt<=0; next state RUN.
  - busy becomes 1 after that same edge.
  - start=0: remain in IDLE.
- RUN, one bit per cycle:
  - Half subtractor 1: d1 = a_sh[0]^b_sh[0], b1 = ~a_sh[0]&b_sh[0].
  - Half subtractor 2: d = d1^bflop, b2 = ~d1&bflop.
  - bout = b1|b2.
  - Each edge: a_sh/b_sh shift right, res_sh <= {d, res_sh[WIDTH-1:1]}, bflop <= bout, cnt++.
  - When cnt==WIDTH-1 at the edge: next state DONE. RUN always lasts exactly WIDTH cycles.
- Entering DONE (same edge as the last bit):
  - diff <= final res_sh including the last bit; borrow <= final bout.
  - done=1 for exactly one cycle, busy still 1.
- DONE: next edge returns to IDLE; done=0, busy=0.
- Latency and throughput:
  - done rises WIDTH edges after the start-accept edge.
  - With start held high, a new operation is accepted every WIDTH+2 cycles.
- diff/borrow never change during RUN; they show the previous result until the new done.
- start asserted in RUN or DONE is ignored; a and b are ignored outside the accept edge.
- Reset mid-RUN: the in-flight operation is discarded; no done pulse is produced.

Optional Feature:
- Macro SERSUB_OVF_EN.
- Defined:
  - Adds port ovf (output, 1).
  - ovf = signed two's-complement overflow = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]).
  - Computed from the captured operand MSBs and the final diff MSB.
  - Registered together with diff on the done edge; reset value 0; holds until the next done.
- Undefined: no ovf port and no associated logic.

Test Plan:
- Reset: drive a=0xFF, b=0x01, start=1, then pulse rst_n=0 asynchronously, no clock edge -> busy=0, done=0, diff=0x00, borrow=0 immediately.
- WIDTH=8, a=0x5A, b=0x23, start pulse -> busy=1 next cycle; done=1 exactly 8 edges after accept; diff=0x37, borrow=0; IDLE one cycle later.
- Borrow/wrap: a=0x10, b=0x20 -> diff=0xF0, borrow=1. a=0x00, b=0x01 -> diff=0xFF, borrow=1. a=b=0xFF -> diff=0x00, borrow=0.
- Ignored start: accept a=0x09, b=0x04; during RUN cycle 3 pulse start with a=0x01, b=0x02 -> single done, diff=0x05, borrow=0. Hold start high -> done pulses every 10 cycles.
- Reset mid-operation: rst_n=0 in RUN cycle 4 -> outputs 0, no done; after release, a=0x80, b=0x7F -> diff=0x01, borrow=0.
- SERSUB_OVF_EN defined: a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow=0. a=0x05, b=0x03 -> ovf=0.
